// File: rtl/pong_pkg.sv
// Shared definitions for the animated pong renderer.
//   - ball_state_e : serve/play state of the ball
//   - default screen size and object colours
//   - in_range()   : inclusive range test used by the renderer and the hit logic
package pong_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        PLAY  = 1'b1
    } ball_state_e;

    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    localparam logic [11:0] WALL_RGB  = 12'h808;
    localparam logic [11:0] BAR_RGB   = 12'hAA0;
    localparam logic [11:0] BALL_RGB  = 12'hAAF;
    localparam logic [11:0] BG_RGB    = 12'hFFF;
    localparam logic [11:0] BLANK_RGB = 12'h000;

    // Inclusive lo <= v <= hi on 10-bit screen coordinates.
    function automatic logic in_range(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pong_refr_tick.sv
// Frame-edge detector for the pong renderer.
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   pixel_x, pixel_y    scan position from the sync generator
//   refr_tick           one-clock pulse per frame, when the scan first reaches
//                       (0, V_RES); holding that position for several clocks
//                       (slow pixel tick) still yields a single pulse
module pong_refr_tick
    import pong_pkg::*;
#(
    parameter int V_RES = V_RES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       refr_tick
);

    localparam logic [9:0] V_RES_W = 10'(V_RES);

    logic frame_end_s;
    logic frame_end_r;
    logic frame_end_d_r;

    assign frame_end_s = (pixel_x == 10'd0) && (pixel_y == V_RES_W);

    // Register the frame-end condition and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_end_r   <= 1'b0;
            frame_end_d_r <= 1'b0;
        end else begin
            frame_end_r   <= frame_end_s;
            frame_end_d_r <= frame_end_r;
        end
    end

    assign refr_tick = frame_end_r & ~frame_end_d_r;

endmodule

// File: rtl/pong_graphics_anim.sv
// Animated pong renderer: fixed wall, button-driven paddle and a bouncing ball.
// Positions, directions and the serve/play state change once per frame.
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   video_on            visible-area flag; blank (000) outside it
//   pixel_x, pixel_y    current scan position
//   btn_up, btn_down    debounced, level-held paddle controls
//   rgb_pic             registered pixel colour, one clock behind pixel_x/pixel_y
//   hit                 one-clock pulse when the ball strikes the paddle
//   miss                one-clock pulse when the ball passes the right edge
// Build option: define ROUND_BALL_EN to draw the ball through an 8x8 circle mask
// (BALL_SIZE must then be 8); otherwise the full square is drawn.
module pong_graphics_anim
    import pong_pkg::*;
#(
    parameter int H_RES        = H_RES_DEF,
    parameter int V_RES        = V_RES_DEF,
    parameter int WALL_X_L     = 32,
    parameter int WALL_X_R     = 35,
    parameter int BAR_X_L      = 600,
    parameter int BAR_W        = 4,
    parameter int BAR_H        = 72,
    parameter int BAR_V        = 4,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_V       = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [11:0] rgb_pic,
    output logic        hit,
    output logic        miss
);

    localparam int CNT_W = $clog2(SERVE_FRAMES);

    localparam logic [9:0] V_RES_W     = 10'(V_RES);
    localparam logic [9:0] WALL_X_L_W  = 10'(WALL_X_L);
    localparam logic [9:0] WALL_X_R_W  = 10'(WALL_X_R);
    localparam logic [9:0] BAR_X_L_W   = 10'(BAR_X_L);
    localparam logic [9:0] BAR_X_R_W   = 10'(BAR_X_L + BAR_W - 1);
    localparam logic [9:0] BAR_H_W     = 10'(BAR_H);
    localparam logic [9:0] BAR_H_M1_W  = 10'(BAR_H - 1);
    localparam logic [9:0] BAR_V_W     = 10'(BAR_V);
    localparam logic [9:0] BAR_Y_RST   = 10'((V_RES - BAR_H) / 2);
    localparam logic [9:0] BALL_S_W    = 10'(BALL_SIZE);
    localparam logic [9:0] BALL_S_M1_W = 10'(BALL_SIZE - 1);
    localparam logic [9:0] BALL_V_W    = 10'(BALL_V);
    localparam logic [9:0] BALL_X0     = 10'(H_RES / 2);
    localparam logic [9:0] BALL_Y0     = 10'(V_RES / 2);
    localparam logic [9:0] MISS_X_W    = 10'(H_RES - 1 - BALL_V);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef ROUND_BALL_EN
    if (BALL_SIZE != 8) begin : g_ball_size_err
        $error("ROUND_BALL_EN requires BALL_SIZE == 8");
    end
`endif

    logic        refr_tick_s;
    ball_state_e state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [9:0]  bar_yt_r, bar_nxt_s, bar_yb_s;
    logic [9:0]  ball_xl_r, ball_xl_nxt_s, ball_xr_s;
    logic [9:0]  ball_yt_r, ball_yt_nxt_s, ball_yb_s;
    logic        dir_x_r, dir_x_nxt_s, dir_x_new_s;   // 1 = moving right
    logic        dir_y_r, dir_y_nxt_s, dir_y_new_s;   // 1 = moving down
    logic        bar_up_ok_s, bar_dn_ok_s;
    logic        wall_bounce_s, bar_hit_s, miss_cond_s;
    logic [9:0]  ball_x_mv_s, ball_y_mv_s;
    logic        hit_nxt_s, miss_nxt_s;
    logic        wall_on_s, bar_on_s, ball_sq_s, ball_on_s;
    logic [11:0] rgb_nxt_s;

    pong_refr_tick #(.V_RES(V_RES)) u_refr_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .refr_tick (refr_tick_s)
    );

    assign bar_yb_s  = bar_yt_r + BAR_H_M1_W;
    assign ball_xr_s = ball_xl_r + BALL_S_M1_W;
    assign ball_yb_s = ball_yt_r + BALL_S_M1_W;

    assign bar_up_ok_s = btn_up & ~btn_down & (bar_yt_r >= BAR_V_W);
    assign bar_dn_ok_s = btn_down & ~btn_up & ((bar_yt_r + BAR_H_W + BAR_V_W) <= V_RES_W);

    // All bounce decisions look at the position before this frame's move.
    assign dir_y_new_s   = (ball_yt_r <= BALL_V_W) ? 1'b1 :
                           ((ball_yt_r + BALL_S_W + BALL_V_W) >= V_RES_W) ? 1'b0 : dir_y_r;
    assign wall_bounce_s = (ball_xl_r <= (WALL_X_R_W + BALL_V_W));
    assign bar_hit_s     = dir_x_r && in_range(ball_xr_s, BAR_X_L_W, BAR_X_R_W) &&
                           (ball_yt_r <= bar_yb_s) && (ball_yb_s >= bar_yt_r);
    assign dir_x_new_s   = bar_hit_s ? 1'b0 : (wall_bounce_s ? 1'b1 : dir_x_r);
    assign miss_cond_s   = (ball_xr_s >= MISS_X_W);

    // The move uses the freshly bounced direction; the clamp keeps it from wrapping below 0.
    assign ball_x_mv_s = dir_x_new_s ? (ball_xl_r + BALL_V_W) :
                         ((ball_xl_r >= BALL_V_W) ? (ball_xl_r - BALL_V_W) : 10'd0);
    assign ball_y_mv_s = dir_y_new_s ? (ball_yt_r + BALL_V_W) :
                         ((ball_yt_r >= BALL_V_W) ? (ball_yt_r - BALL_V_W) : 10'd0);

    // Per-frame next state for paddle, ball, directions and the serve/play FSM
    always_comb begin
        bar_nxt_s     = bar_yt_r;
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        ball_xl_nxt_s = ball_xl_r;
        ball_yt_nxt_s = ball_yt_r;
        dir_x_nxt_s   = dir_x_r;
        dir_y_nxt_s   = dir_y_r;
        hit_nxt_s     = 1'b0;
        miss_nxt_s    = 1'b0;
        if (refr_tick_s) begin
            if (bar_up_ok_s) begin
                bar_nxt_s = bar_yt_r - BAR_V_W;
            end else if (bar_dn_ok_s) begin
                bar_nxt_s = bar_yt_r + BAR_V_W;
            end else begin
                bar_nxt_s = bar_yt_r;
            end
            case (state_r)
                SERVE: begin
                    ball_xl_nxt_s = BALL_X0;
                    ball_yt_nxt_s = BALL_Y0;
                    if (cnt_r == SERVE_LAST) begin
                        state_nxt_s = PLAY;
                        cnt_nxt_s   = CNT_ZERO;
                        dir_x_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                PLAY: begin
                    dir_x_nxt_s = dir_x_new_s;
                    dir_y_nxt_s = dir_y_new_s;
                    hit_nxt_s   = bar_hit_s;
                    if (miss_cond_s) begin
                        miss_nxt_s    = 1'b1;
                        state_nxt_s   = SERVE;
                        cnt_nxt_s     = CNT_ZERO;
                        ball_xl_nxt_s = BALL_X0;
                        ball_yt_nxt_s = BALL_Y0;
                    end else begin
                        ball_xl_nxt_s = ball_x_mv_s;
                        ball_yt_nxt_s = ball_y_mv_s;
                    end
                end
                default: begin
                    state_nxt_s   = SERVE;
                    cnt_nxt_s     = CNT_ZERO;
                    ball_xl_nxt_s = BALL_X0;
                    ball_yt_nxt_s = BALL_Y0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Game state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= SERVE;
            cnt_r     <= CNT_ZERO;
            bar_yt_r  <= BAR_Y_RST;
            ball_xl_r <= BALL_X0;
            ball_yt_r <= BALL_Y0;
            dir_x_r   <= 1'b1;
            dir_y_r   <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            bar_yt_r  <= bar_nxt_s;
            ball_xl_r <= ball_xl_nxt_s;
            ball_yt_r <= ball_yt_nxt_s;
            dir_x_r   <= dir_x_nxt_s;
            dir_y_r   <= dir_y_nxt_s;
        end
    end

    assign wall_on_s = in_range(pixel_x, WALL_X_L_W, WALL_X_R_W);
    assign bar_on_s  = in_range(pixel_x, BAR_X_L_W, BAR_X_R_W) && in_range(pixel_y, bar_yt_r, bar_yb_s);
    assign ball_sq_s = in_range(pixel_x, ball_xl_r, ball_xr_s) && in_range(pixel_y, ball_yt_r, ball_yb_s);

`ifdef ROUND_BALL_EN
    // Row bitmap of the round ball; symmetric, so bit order does not matter.
    function automatic logic [7:0] ball_rom(input logic [2:0] row);
        case (row)
            3'd0:    return 8'b0011_1100;
            3'd1:    return 8'b0111_1110;
            3'd2:    return 8'b1111_1111;
            3'd3:    return 8'b1111_1111;
            3'd4:    return 8'b1111_1111;
            3'd5:    return 8'b1111_1111;
            3'd6:    return 8'b0111_1110;
            3'd7:    return 8'b0011_1100;
            default: return 8'b0000_0000;
        endcase
    endfunction

    logic [2:0] rom_row_s, rom_col_s;
    logic [7:0] rom_bits_s;
    assign rom_row_s  = 3'(pixel_y - ball_yt_r);
    assign rom_col_s  = 3'(pixel_x - ball_xl_r);
    assign rom_bits_s = ball_rom(rom_row_s);
    assign ball_on_s  = ball_sq_s && rom_bits_s[rom_col_s];
`else
    assign ball_on_s  = ball_sq_s;
`endif

    // Colour selection: wall over paddle over ball over background
    always_comb begin
        rgb_nxt_s = BLANK_RGB;
        if (!video_on) begin
            rgb_nxt_s = BLANK_RGB;
        end else if (wall_on_s) begin
            rgb_nxt_s = WALL_RGB;
        end else if (bar_on_s) begin
            rgb_nxt_s = BAR_RGB;
        end else if (ball_on_s) begin
            rgb_nxt_s = BALL_RGB;
        end else begin
            rgb_nxt_s = BG_RGB;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_pic <= BLANK_RGB;
            hit     <= 1'b0;
            miss    <= 1'b0;
        end else begin
            rgb_pic <= rgb_nxt_s;
            hit     <= hit_nxt_s;
            miss    <= miss_nxt_s;
        end
    end

endmodule

// File: tb/tb_pong_graphics_anim.sv
// Scoreboard bench for pong_graphics_anim. Stimulus drives frame ticks and pixel
// probes and pushes expected responses, tagged with the cycle they are due, into
// a queue; a monitor on the falling edge pops and compares them.
module tb_pong_graphics_anim;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        btn_up;
    logic        btn_down;
    logic [11:0] rgb_pic;
    logic        hit;
    logic        miss;

    always #5 clk = ~clk;

    pong_graphics_anim dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .video_on (video_on),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .rgb_pic  (rgb_pic),
        .hit      (hit),
        .miss     (miss)
    );

    typedef struct {
        int          due;
        bit          chk_rgb;
        logic [11:0] rgb;
        bit          hit;
        bit          miss;
        int          px;
        int          py;
    } item_t;

    item_t sbq[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int dut_hits = 0;
    int dut_misses = 0;

    // Reference model: plain integer game state
    int m_bar, m_bx, m_by, m_dx, m_dy, m_cnt;
    bit m_serving;
    int m_hits = 0;
    int m_misses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count pulses and retire every expectation that falls due this cycle
    always @(negedge clk) begin
        item_t it;
        if (reset_n === 1'b1 && hit === 1'b1) dut_hits++;
        if (reset_n === 1'b1 && miss === 1'b1) dut_misses++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            it = sbq.pop_front();
            if (it.due < cyc) begin
                checks++; errors++;
                $display("FAIL stale_item due %0d now %0d", it.due, cyc);
            end else begin
                if (it.chk_rgb) begin
                    checks++;
                    if (rgb_pic !== it.rgb) begin
                        errors++;
                        $display("FAIL rgb_pic at (%0d,%0d) cyc %0d: got %h want %h",
                                 it.px, it.py, cyc, rgb_pic, it.rgb);
                    end
                end
                checks++;
                if (hit !== it.hit) begin
                    errors++;
                    $display("FAIL hit cyc %0d: got %b want %b", cyc, hit, it.hit);
                end
                checks++;
                if (miss !== it.miss) begin
                    errors++;
                    $display("FAIL miss cyc %0d: got %b want %b", cyc, miss, it.miss);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic void model_reset();
        m_bar = (480 - 72) / 2;
        m_bx = 320; m_by = 240;
        m_dx = 1; m_dy = 1;
        m_cnt = 0; m_serving = 1'b1;
    endfunction

    function automatic void model_frame(input bit up, input bit dn, output bit h, output bit m);
        int xr;
        h = 1'b0; m = 1'b0;
        if (m_serving) begin
            if (m_cnt == 59) begin
                m_serving = 1'b0; m_cnt = 0; m_dx = 1;
            end else begin
                m_cnt++;
            end
        end else begin
            if (m_by <= 2) m_dy = 1;
            else if (m_by + 10 >= 480) m_dy = -1;
            if (m_bx <= 37) m_dx = 1;
            xr = m_bx + 7;
            if (m_dx == 1 && xr >= 600 && xr <= 603 && m_by <= m_bar + 71 && m_by + 7 >= m_bar) begin
                m_dx = -1; h = 1'b1;
            end
            if (xr >= 637) begin
                m = 1'b1; m_bx = 320; m_by = 240; m_serving = 1'b1; m_cnt = 0;
            end else begin
                m_bx += 2 * m_dx;
                m_by += 2 * m_dy;
                if (m_bx < 0) m_bx = 0;
                if (m_by < 0) m_by = 0;
            end
        end
        // The paddle moves after the hit test, which used its old position.
        if (up && !dn && m_bar >= 4) m_bar -= 4;
        else if (dn && !up && m_bar + 76 <= 480) m_bar += 4;
        if (h) m_hits++;
        if (m) m_misses++;
    endfunction

    function automatic logic [11:0] model_rgb(input int x, input int y, input bit von);
        int cx, cy;
        bit in_ball;
        if (!von) return 12'h000;
        if (x >= 32 && x <= 35) return 12'h808;
        if (x >= 600 && x <= 603 && y >= m_bar && y < m_bar + 72) return 12'hAA0;
        cx = x - m_bx; cy = y - m_by;
        in_ball = (cx >= 0 && cx < 8 && cy >= 0 && cy < 8);
`ifdef ROUND_BALL_EN
        if (in_ball && ((2*cx-7)*(2*cx-7) + (2*cy-7)*(2*cy-7) > 64)) in_ball = 1'b0;
`endif
        if (in_ball) return 12'hAAF;
        return 12'hFFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int due, input bit chk, input logic [11:0] rgb,
                        input bit h, input bit m, input int px, input int py);
        item_t it;
        it.due = due; it.chk_rgb = chk; it.rgb = rgb;
        it.hit = h; it.miss = m; it.px = px; it.py = py;
        sbq.push_back(it);
    endtask

    task automatic probe(input int x, input int y, input bit von);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = von;
        push(cyc + 1, 1'b1, model_rgb(x, y, von), 1'b0, 1'b0, x, y);
        step();
    endtask

    task automatic reset_probe();
        pixel_x = 10'd33; pixel_y = 10'd100; video_on = 1'b1;
        push(cyc + 1, 1'b1, 12'h000, 1'b0, 1'b0, 33, 100);
        step();
    endtask

    // One frame tick; the tick position is held for 'hold' clocks (>= 2).
    task automatic frame(input bit up, input bit dn, input int hold);
        bit h, m;
        btn_up = up; btn_down = dn;
        pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0;
        model_frame(up, dn, h, m);
        push(cyc + 2, 1'b0, 12'h000, h, m, 0, 480);
        push(cyc + 3, 1'b0, 12'h000, 1'b0, 1'b0, 0, 480);
        repeat (hold) step();
    endtask

    task automatic probe_set();
        probe(m_bx, m_by, 1'b1);
        probe(m_bx + 7, m_by + 7, 1'b1);
        probe(m_bx - 1, m_by + 3, 1'b1);
        probe(m_bx + 8, m_by + 3, 1'b1);
        probe(m_bx + 3, m_by - 1, 1'b1);
        probe(601, m_bar, 1'b1);
        probe(601, m_bar + 71, 1'b1);
        if (m_bar > 0) probe(601, m_bar - 1, 1'b1);
        probe(601, m_bar + 72, 1'b1);
        probe(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom_range(0, 1)));
    endtask

    // mode: 0 idle, 1 up held, 2 both held, 3 track the ball, 4 random buttons
    task automatic play_frames(input int n, input int mode);
        bit up, dn;
        int bc, pc;
        for (int i = 0; i < n; i++) begin
            up = 1'b0; dn = 1'b0;
            case (mode)
                1: up = 1'b1;
                2: begin up = 1'b1; dn = 1'b1; end
                3: begin
                    bc = m_by + 4; pc = m_bar + 36;
                    if ($urandom_range(0, 9) < 2) begin
                        up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1));
                    end else if (pc < bc - 3) dn = 1'b1;
                    else if (pc > bc + 3) up = 1'b1;
                end
                4: begin
                    up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1));
                end
                default: begin up = 1'b0; dn = 1'b0; end
            endcase
            frame(up, dn, int'($urandom_range(2, 4)));
            probe_set();
        end
    endtask

    initial begin
        reset_n = 1'b0; video_on = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        pixel_x = 10'd1; pixel_y = 10'd1;
        model_reset();
        repeat (2) step();
        reset_probe();
        reset_probe();
        reset_n = 1'b1;
        model_reset();

        probe(33, 100, 1'b1);
        probe(601, 210, 1'b1);
        probe(320, 240, 1'b1);
        probe(327, 247, 1'b1);
        probe(601, 203, 1'b1);
        probe(33, 100, 1'b0);

        play_frames(61, 0);
        play_frames(100, 1);
        play_frames(10, 2);
        play_frames(400, 3);
        play_frames(400, 4);

        // Reset in the middle of play, away from the tick position
        repeat (4) step();
        pixel_x = 10'd5; pixel_y = 10'd5;
        reset_n = 1'b0;
        reset_probe();
        reset_probe();
        reset_n = 1'b1;
        model_reset();
        probe(320, 240, 1'b1);
        probe(601, 204, 1'b1);
        play_frames(70, 4);

        repeat (5) step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d items left, want 0", sbq.size());
        end
        checks++;
        if (dut_hits != m_hits) begin
            errors++;
            $display("FAIL hit_count: got %0d want %0d", dut_hits, m_hits);
        end
        checks++;
        if (dut_misses != m_misses) begin
            errors++;
            $display("FAIL miss_count: got %0d want %0d", dut_misses, m_misses);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
